// File: rtl/sram_mem_ctrl_if.sv
// sram_mem_ctrl_if: pipeline-side request/response signals plus the external
// asynchronous SRAM pins of the memory-stage controller.
// slave  = controller side, master = pipeline/SRAM side.
interface sram_mem_ctrl_if #(
    parameter int ADDR_W = 18
);
    // pipeline side
    logic              mem_rden;
    logic              mem_wren;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [3:0]        bmask;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic              sram_stall;
    // SRAM pins
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_o;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_i;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_lb_n;
    logic              sram_ub_n;

    modport slave (
        input  mem_rden, mem_wren, addr, wdata, bmask, sram_dq_i,
        output rdata, rdata_valid, sram_stall,
        output sram_addr, sram_dq_o, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
    );

    modport master (
        output mem_rden, mem_wren, addr, wdata, bmask, sram_dq_i,
        input  rdata, rdata_valid, sram_stall,
        input  sram_addr, sram_dq_o, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
    );
endinterface

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: splits one 32-bit load/store into two 16-bit accesses on an
// external asynchronous SRAM, stalling the pipeline for the duration.
// Optional build macro SRAM_MEM_CTRL_HALF_SKIP_EN: stores skip any half whose
// two byte lanes are both disabled.
module sram_mem_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    sram_mem_ctrl_if.slave bus
);
    localparam int CW = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t              state, nxt_state;
    logic [CW-1:0]       cnt, nxt_cnt;

    // captured request
    logic                op_wr;
    logic [ADDR_W-2:0]   a_q;
    logic [31:0]         wd_q;
    logic [3:0]          bm_q;

    // request as seen by the next cycle (fresh on accept, captured otherwise)
    logic                req, accept;
    logic                nxt_wr;
    logic [ADDR_W-2:0]   nxt_a;
    logic [31:0]         nxt_wd;
    logic [3:0]          nxt_bm;
    logic                skip_lo, skip_hi;

    // registered pins and their next values
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         dq_o_q, dq_o_d;
    logic                dq_oe_q, dq_oe_d;
    logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic                half;
    logic [1:0]          lanes;

    // read path
    logic [15:0]         lo_buf;
    logic [31:0]         rdata_q;
    logic                valid_q;

    logic                unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:ADDR_W+1], bus.addr[1:0]};

    assign req    = bus.mem_rden | bus.mem_wren;
    assign accept = (state == IDLE) && req;

    // a simultaneous load+store request is treated as a store
    assign nxt_wr = accept ? bus.mem_wren            : op_wr;
    assign nxt_a  = accept ? bus.addr[ADDR_W:2]      : a_q;
    assign nxt_wd = accept ? bus.wdata               : wd_q;
    assign nxt_bm = accept ? bus.bmask               : bm_q;

`ifdef SRAM_MEM_CTRL_HALF_SKIP_EN
    assign skip_lo = nxt_wr && (nxt_bm[1:0] == 2'b00);
    assign skip_hi = nxt_wr && (nxt_bm[3:2] == 2'b00);
`else
    assign skip_lo = 1'b0;
    assign skip_hi = 1'b0;
`endif

    assign bus.sram_stall = !rst && (accept || state == LO || state == HI);

    // state and phase counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    // next-state / phase-counter logic
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        unique case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (req) begin
                    if (!skip_lo)      nxt_state = LO;
                    else if (!skip_hi) nxt_state = HI;
                    else               nxt_state = DONE;
                end
            end
            LO: begin
                if (cnt == LAST) begin
                    nxt_cnt   = '0;
                    nxt_state = skip_hi ? DONE : HI;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            HI: begin
                if (cnt == LAST) begin
                    nxt_cnt   = '0;
                    nxt_state = DONE;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            default: begin
                nxt_cnt   = '0;
                nxt_state = IDLE;
            end
        endcase
    end

    // pin values for the cycle being entered; registered so every pin
    // changes only on the edge that starts a phase cycle
    always_comb begin
        addr_d  = addr_q;
        dq_o_d  = dq_o_q;
        dq_oe_d = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        half    = (nxt_state == HI);
        lanes   = half ? nxt_bm[3:2] : nxt_bm[1:0];
        if (nxt_state == LO || nxt_state == HI) begin
            ce_n_d = 1'b0;
            addr_d = {nxt_a, half};
            dq_o_d = half ? nxt_wd[31:16] : nxt_wd[15:0];
            if (nxt_wr) begin
                dq_oe_d = 1'b1;
                lb_n_d  = ~lanes[0];
                ub_n_d  = ~lanes[1];
                // first phase cycle is address/data setup; no pulse if no lane
                we_n_d  = (nxt_cnt == '0) || (lanes == 2'b00);
            end else begin
                oe_n_d = 1'b0;
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
        end
    end

    // request capture on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr <= 1'b0;
            a_q   <= '0;
            wd_q  <= '0;
            bm_q  <= '0;
        end else if (accept) begin
            op_wr <= bus.mem_wren;
            a_q   <= bus.addr[ADDR_W:2];
            wd_q  <= bus.wdata;
            bm_q  <= bus.bmask;
        end
    end

    // SRAM pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            dq_o_q  <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
        end else begin
            addr_q  <= addr_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            lb_n_q  <= lb_n_d;
            ub_n_q  <= ub_n_d;
        end
    end

    // load data: low half buffered, full word published on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_buf  <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!op_wr && cnt == LAST) begin
                if (state == LO) begin
                    lo_buf <= bus.sram_dq_i;
                end else if (state == HI) begin
                    rdata_q <= {bus.sram_dq_i, lo_buf};
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = valid_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_o   = dq_o_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_lb_n   = lb_n_q;
    assign bus.sram_ub_n   = ub_n_q;
endmodule
